// File: rtl/pgr_apb_master_arb_32bit.sv
// Two-requester round-robin APB master arbiter: one complete transfer per grant,
// with an optional per-transfer PREADY timeout that reports err and all-ones read data.
module pgr_apb_master_arb_32bit #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic [SW-1:0] i_m0_strb,
    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic [SW-1:0] i_m1_strb,
    output logic          o_m0_done,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_rdata,
    output logic          o_m1_done,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_p_sel,
    output logic          o_p_enable,
    output logic          o_p_we,
    output logic [AW-1:0] o_p_addr,
    output logic [DW-1:0] o_p_wdata,
    output logic [SW-1:0] o_p_strb,
    input  logic          i_p_ready,
    input  logic [DW-1:0] i_p_rdata,
    output logic [1:0]    o_grant,
    output logic          o_busy
);

    localparam int          CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state;
    logic          last_grant;   // 1 = m1 owned the previous transfer
    logic [CW-1:0] cnt;
    logic          pick_m1;

    // m1 wins when alone, or on a tie when m0 had the previous grant.
    always_comb begin
        pick_m1 = i_m1_req && (!i_m0_req || !last_grant);
    end

    // NOTE: every register here, including the wide data registers, is cleared by the
    // async reset so no X can ever reach the APB bus or a requester after reset.
    // NOTE: non-blocking assignments only, so all branches see pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            o_m0_done  <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m0_rdata <= '0;
            o_m1_done  <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m1_rdata <= '0;
            o_p_sel    <= 1'b0;
            o_p_enable <= 1'b0;
            o_p_we     <= 1'b0;
            o_p_addr   <= '0;
            o_p_wdata  <= '0;
            o_p_strb   <= '0;
            o_grant    <= 2'b00;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        state      <= SETUP;
                        o_busy     <= 1'b1;
                        o_p_sel    <= 1'b1;
                        o_p_enable <= 1'b0;
                        last_grant <= pick_m1;
                        o_grant    <= pick_m1 ? 2'b10 : 2'b01;
                        o_p_we     <= pick_m1 ? i_m1_we    : i_m0_we;
                        o_p_addr   <= pick_m1 ? i_m1_addr  : i_m0_addr;
                        o_p_wdata  <= pick_m1 ? i_m1_wdata : i_m0_wdata;
                        o_p_strb   <= pick_m1 ? i_m1_strb  : i_m0_strb;
                    end
                end
                SETUP: begin
                    state      <= ACCESS;
                    o_p_enable <= 1'b1;
                    cnt        <= '0;
                end
                ACCESS: begin
                    if (i_p_ready) begin
                        state      <= DONE;
                        o_p_sel    <= 1'b0;
                        o_p_enable <= 1'b0;
                        if (o_grant[1]) begin
                            o_m1_done <= 1'b1;
                            if (!o_p_we) o_m1_rdata <= i_p_rdata;
                        end else begin
                            o_m0_done <= 1'b1;
                            if (!o_p_we) o_m0_rdata <= i_p_rdata;
                        end
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        state      <= DONE;
                        o_p_sel    <= 1'b0;
                        o_p_enable <= 1'b0;
                        if (o_grant[1]) begin
                            o_m1_done  <= 1'b1;
                            o_m1_err   <= 1'b1;
                            o_m1_rdata <= '1;
                        end else begin
                            o_m0_done  <= 1'b1;
                            o_m0_err   <= 1'b1;
                            o_m0_rdata <= '1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    o_m0_done <= 1'b0;
                    o_m0_err  <= 1'b0;
                    o_m1_done <= 1'b0;
                    o_m1_err  <= 1'b0;
                    o_grant   <= 2'b00;
                    o_busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgr_apb_master_arb_32bit.sv
// Directed bench for the two-port APB arbiter: cycle-exact checks of grant order,
// APB phase timing, read data routing, timeout and async reset behaviour.
`timescale 1ns/1ps
module tb_pgr_apb_master_arb_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        p_sel, p_enable, p_we;
    logic [15:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_ready;
    logic [31:0] p_rdata;
    logic [1:0]  grant;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pgr_apb_master_arb_32bit #(.AW(16), .DW(32), .SW(4), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_strb(m0_strb),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_strb(m1_strb),
        .o_m0_done(m0_done), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
        .o_m1_done(m1_done), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
        .o_p_sel(p_sel), .o_p_enable(p_enable), .o_p_we(p_we),
        .o_p_addr(p_addr), .o_p_wdata(p_wdata), .o_p_strb(p_strb),
        .i_p_ready(p_ready), .i_p_rdata(p_rdata),
        .o_grant(grant), .o_busy(busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Packed status view: {sel, enable, busy, grant[1:0], m0_done, m0_err, m1_done, m1_err}
    function automatic logic [8:0] status();
        return {p_sel, p_enable, busy, grant, m0_done, m0_err, m1_done, m1_err};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
        p_ready = 1'b1; p_rdata = '0;
        tick(); tick();
        checks++;
        if (status() !== 9'b0) begin
            errors++; $display("FAIL reset_status got=%b exp=%b", status(), 9'b0);
        end
        checks++;
        if ({p_we, p_addr, p_wdata, p_strb} !== 53'b0) begin
            errors++; $display("FAIL reset_bus got=%h exp=0", {p_we, p_addr, p_wdata, p_strb});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'b0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_m0_write();
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 32'hA5A5_1234; m0_strb = 4'hF;
        tick();  // T+1
        checks++;
        if (status() !== 9'b1_0_1_01_0000) begin
            errors++; $display("FAIL t1_setup got=%b exp=%b", status(), 9'b101010000);
        end
        checks++;
        if ({p_we, p_addr, p_wdata, p_strb} !== {1'b1, 16'h0010, 32'hA5A5_1234, 4'hF}) begin
            errors++; $display("FAIL t1_bus got=%h exp=%h", {p_we, p_addr, p_wdata, p_strb},
                               {1'b1, 16'h0010, 32'hA5A5_1234, 4'hF});
        end
        tick();  // T+2
        checks++;
        if (status() !== 9'b1_1_1_01_0000) begin
            errors++; $display("FAIL t1_access got=%b exp=%b", status(), 9'b111010000);
        end
        tick();  // T+3
        checks++;
        if (status() !== 9'b0_0_1_01_1000) begin
            errors++; $display("FAIL t1_done got=%b exp=%b", status(), 9'b001011000);
        end
        m0_req = 0;
        tick();  // T+4
        checks++;
        if (status() !== 9'b0) begin
            errors++; $display("FAIL t1_idle got=%b exp=%b", status(), 9'b0);
        end
        checks++;
        if (p_addr !== 16'h0010) begin
            errors++; $display("FAIL t1_addr_hold got=%h exp=%h", p_addr, 16'h0010);
        end
    endtask

    task automatic test_m1_read_wait();
        p_ready = 0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0044; m1_wdata = '0; m1_strb = 4'h0;
        tick();  // SETUP
        checks++;
        if (status() !== 9'b1_0_1_10_0000) begin
            errors++; $display("FAIL t2_setup got=%b exp=%b", status(), 9'b101100000);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (status() !== 9'b1_1_1_10_0000) begin
                errors++; $display("FAIL t2_wait%0d got=%b exp=%b", i, status(), 9'b111100000);
            end
            tick();
        end
        p_ready = 1; p_rdata = 32'hCAFE_0001;
        tick();
        checks++;
        if (status() !== 9'b0_0_1_10_0010) begin
            errors++; $display("FAIL t2_done got=%b exp=%b", status(), 9'b001100010);
        end
        checks++;
        if ({m1_rdata, m0_rdata} !== {32'hCAFE_0001, 32'h0}) begin
            errors++; $display("FAIL t2_rdata got=%h exp=%h", {m1_rdata, m0_rdata}, {32'hCAFE_0001, 32'h0});
        end
        m1_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wdata = 32'h0000_00AA; m0_strb = 4'h3;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            p_rdata = 32'h3000_0000 + 32'(k);
            tick();
            checks++;
            if ({grant, p_sel, p_enable, p_addr} !== {exp_g, 2'b10, (k % 2 == 0) ? 16'h0100 : 16'h0200}) begin
                errors++; $display("FAIL t3_grant%0d got=%b/%h exp=%b", k, grant, p_addr, exp_g);
            end
            tick(); tick();
            checks++;
            if ({m0_done, m1_done} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL t3_done%0d got=%b exp=%b", k, {m0_done, m1_done},
                                   (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (k % 2 == 1) begin
                checks++;
                if (m1_rdata !== 32'h3000_0000 + 32'(k)) begin
                    errors++; $display("FAIL t3_rdata%0d got=%h exp=%h", k, m1_rdata, 32'h3000_0000 + 32'(k));
                end
            end
            if (k == 3) begin m0_req = 0; m1_req = 0; end
            tick();
            checks++;
            if ({grant, busy} !== 3'b000) begin
                errors++; $display("FAIL t3_idle%0d got=%b exp=000", k, {grant, busy});
            end
        end
    endtask

    task automatic test_timeout();
        p_ready = 0;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0300;
        tick();  // SETUP
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (status() !== 9'b1_1_1_01_0000) begin
                errors++; $display("FAIL t4_access%0d got=%b exp=%b", i, status(), 9'b111010000);
            end
        end
        tick();
        checks++;
        if (status() !== 9'b0_0_1_01_1100) begin
            errors++; $display("FAIL t4_done_err got=%b exp=%b", status(), 9'b001011100);
        end
        checks++;
        if (m0_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL t4_rdata got=%h exp=%h", m0_rdata, 32'hFFFF_FFFF);
        end
        m0_req = 0;
        tick();
        checks++;
        if (status() !== 9'b0) begin
            errors++; $display("FAIL t4_idle got=%b exp=%b", status(), 9'b0);
        end
        // Bus recovers: a following m1 write completes normally.
        p_ready = 1;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0304; m1_wdata = 32'h0BAD_F00D; m1_strb = 4'hF;
        tick(); tick(); tick();
        checks++;
        if (status() !== 9'b0_0_1_10_0010) begin
            errors++; $display("FAIL t4_next got=%b exp=%b", status(), 9'b001100010);
        end
        m1_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        p_ready = 0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0400;
        tick(); tick();  // ACCESS
        #2 rst_n = 0;
        #1;
        checks++;
        if ({p_sel, p_enable, grant, busy} !== 5'b0) begin
            errors++; $display("FAIL t5_async got=%b exp=00000", {p_sel, p_enable, grant, busy});
        end
        tick();
        checks++;
        if ({m0_done, m0_err, m1_done, m1_err, m1_rdata} !== 36'b0) begin
            errors++; $display("FAIL t5_nodone got=%h exp=0", {m0_done, m0_err, m1_done, m1_err, m1_rdata});
        end
        rst_n = 1;
        p_ready = 1;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0500;
        tick();
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL t5_tie got=%b exp=01", grant);
        end
        tick(); tick();
        checks++;
        if ({m0_done, m1_done} !== 2'b10) begin
            errors++; $display("FAIL t5_done got=%b exp=10", {m0_done, m1_done});
        end
        m0_req = 0; m1_req = 0;
        tick();
    endtask

    task automatic test_req_drop();
        int pulses = 0;
        p_ready = 0;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0600;
        tick(); tick();  // ACCESS
        m1_req = 0;
        tick();
        p_ready = 1; p_rdata = 32'h5A5A_0006;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m1_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL t6_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if ({m1_rdata, grant, busy} !== {32'h5A5A_0006, 3'b000}) begin
            errors++; $display("FAIL t6_final got=%h exp=%h", {m1_rdata, grant, busy}, {32'h5A5A_0006, 3'b000});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_transfer();
        test_req_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
